sng_multi: RTL and testbench

- Multi-channel stochastic number generator with built-in noise sources.
- Accepts a vector of NUM_CH binary values through a valid/ready load handshake, then emits a fixed-length bitstream per channel, one bit per channel per clock.
- Each channel has its own maximal-length LFSR, or all channels share one LFSR, selected by parameter.
- Sits between binary producers and the stochastic arithmetic fabric; replaces per-channel single SNG instances.

---
 rtl/sc_pkg.sv | 40 ++++
 rtl/sng_multi_if.sv | 23 ++
 rtl/lfsr.sv | 41 ++++
 rtl/sng_multi.sv | 117 +++++++++++
 tb/tb_sng_multi.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types, LFSR tap table and seed helper for sng_multi
package sc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sng_state_e;

    // Maximal-length Fibonacci tap masks; bit i set means stage i+1 feeds back.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    // Per-channel seed; zero would lock the LFSR, so it is bumped to 1.
    function automatic logic [15:0] seed_for(input int width, input int seed,
                                             input int stride, input int ch);
        int s;
        s = (seed + ch * stride) % (1 << width);
        if (s == 0) begin
            s = 1;
        end
        return s[15:0];
    endfunction

endpackage

// File: rtl/sng_multi_if.sv
// rtl/sng_multi_if.sv - load handshake and bitstream bundle for sng_multi
interface sng_multi_if #(
    parameter int PRECISION = 8,
    parameter int NUM_CH    = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_CH*PRECISION-1:0] in_data;
    logic                        stop;
    logic                        out_valid;
    logic [NUM_CH-1:0]           out_bits;
    logic                        done;

    modport master (
        output in_valid, in_data, stop,
        input  in_ready, out_valid, out_bits, done
    );

    modport slave (
        input  in_valid, in_data, stop,
        output in_ready, out_valid, out_bits, done
    );
endinterface

// File: rtl/lfsr.sv
// rtl/lfsr.sv - Fibonacci maximal-length LFSR with synchronous seed reload
import sc_pkg::*;

module lfsr #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] state
);
    localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Reload wins over stepping so a fresh stream always starts at the seed.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (en) begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    // State register, seeded on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sng_multi.sv
// rtl/sng_multi.sv - multi-channel stochastic number generator
import sc_pkg::*;

module sng_multi #(
    parameter int PRECISION   = 8,
    parameter int NUM_CH      = 4,
    parameter int STREAM_LEN  = 2**PRECISION - 1,
    parameter int SHARED_RNG  = 0,
    parameter int SEED        = 1,
    parameter int SEED_STRIDE = 37
) (
    input logic        clk,
    input logic        rst,
    sng_multi_if.slave bus
);
    localparam int                   NUM_RNG  = (SHARED_RNG != 0) ? 1 : NUM_CH;
    localparam logic [PRECISION-1:0] LAST_IDX = PRECISION'(STREAM_LEN - 1);

    sng_state_e                  state_q, state_d;
    logic [PRECISION-1:0]        cnt_q, cnt_d;
    logic [NUM_CH*PRECISION-1:0] val_q, val_d;
    logic                        out_valid_q, out_valid_d;
    logic [NUM_CH-1:0]           out_bits_q, out_bits_d;
    logic                        done_q, done_d;

    logic                        load_w;
    logic                        advance_w;
    logic [PRECISION-1:0]        rng [NUM_RNG];
    logic [NUM_CH-1:0]           cmp_bits;

    assign bus.in_ready = (state_q == ST_IDLE);
    assign load_w       = bus.in_valid && (state_q == ST_IDLE);
    assign advance_w    = (state_q == ST_RUN) && !bus.stop;

    for (genvar g = 0; g < NUM_RNG; g++) begin : g_rng
        lfsr #(
            .WIDTH (PRECISION),
            .SEED  (PRECISION'(seed_for(PRECISION, SEED, SEED_STRIDE, g)))
        ) u_lfsr (
            .clk   (clk),
            .rst   (rst),
            .load  (load_w),
            .en    (advance_w),
            .state (rng[g])
        );
    end

    // A bit is one when the random draw does not exceed the channel value.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_cmp
        if (SHARED_RNG != 0) begin : g_shared
            assign cmp_bits[k] = (rng[0] <= val_q[k*PRECISION +: PRECISION]);
        end else begin : g_indep
            assign cmp_bits[k] = (rng[k] <= val_q[k*PRECISION +: PRECISION]);
        end
    end

    // Next-state: load in IDLE, emit or abort in RUN; stop beats end-of-stream.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        val_d       = val_q;
        out_valid_d = 1'b0;
        out_bits_d  = '0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    val_d   = bus.in_data;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    out_bits_d  = cmp_bits;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + PRECISION'(1);
                    if (cnt_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any stream without a done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            val_q       <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            val_q       <= val_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_bits  = out_bits_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sng_multi.sv
// tb/tb_sng_multi.sv - self-checking bench for sng_multi
module tb_sng_multi;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sng_multi_if #(.PRECISION(8), .NUM_CH(2)) ifa ();
    sng_multi_if #(.PRECISION(8), .NUM_CH(2)) ifb ();

    sng_multi #(
        .PRECISION(8), .NUM_CH(2), .STREAM_LEN(255),
        .SHARED_RNG(0), .SEED(1), .SEED_STRIDE(37)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    sng_multi #(
        .PRECISION(8), .NUM_CH(2), .STREAM_LEN(16),
        .SHARED_RNG(1), .SEED(1), .SEED_STRIDE(37)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    bit       m_busy  [2];
    int       m_pos   [2];
    int       m_len   [2] = '{255, 16};
    bit       m_shared[2] = '{1'b0, 1'b1};
    bit [1:0] exp_s   [2][256];
    bit       e_valid [2];
    bit [1:0] e_bits  [2];
    bit       e_done  [2];

    bit [1:0] cap_a[$];
    bit [1:0] cap_b[$];
    bit [1:0] first_stream[$];
    bit       vb[$];
    int       done_cnt_a = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic bit [7:0] lfsr_step(input bit [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic bit [7:0] seed_of(input int ch);
        int s;
        s = (1 + 37 * ch) % 256;
        return (s == 0) ? 8'd1 : s[7:0];
    endfunction

    task automatic build(input int d, input bit [15:0] data);
        bit [7:0] r0, r1, rr1;
        r0 = seed_of(0);
        r1 = seed_of(1);
        for (int i = 0; i < m_len[d]; i++) begin
            rr1 = m_shared[d] ? r0 : r1;
            exp_s[d][i] = {(rr1 <= data[15:8]), (r0 <= data[7:0])};
            r0 = lfsr_step(r0);
            r1 = lfsr_step(r1);
        end
    endtask

    task automatic model_step(input int d, input bit iv, input bit [15:0] data, input bit st);
        if (m_busy[d]) begin
            if (st) begin
                m_busy[d]  = 1'b0;
                e_valid[d] = 1'b0;
                e_done[d]  = 1'b0;
                e_bits[d]  = 2'b00;
            end else begin
                e_bits[d]  = exp_s[d][m_pos[d]];
                e_valid[d] = 1'b1;
                e_done[d]  = (m_pos[d] == m_len[d] - 1);
                m_pos[d]++;
                if (m_pos[d] == m_len[d]) m_busy[d] = 1'b0;
            end
        end else begin
            e_valid[d] = 1'b0;
            e_done[d]  = 1'b0;
            e_bits[d]  = 2'b00;
            if (iv) begin
                build(d, data);
                m_busy[d] = 1'b1;
                m_pos[d]  = 0;
            end
        end
    endtask

    task automatic model_reset(input int d);
        m_busy[d]  = 1'b0;
        m_pos[d]   = 0;
        e_valid[d] = 1'b0;
        e_done[d]  = 1'b0;
        e_bits[d]  = 2'b00;
    endtask

    task automatic compare(input int d, input bit rdy, input bit v, input bit [1:0] b, input bit dn);
        string nm;
        nm = (d == 0) ? "A" : "B";
        chk({nm, ".in_ready"}, rdy, !m_busy[d]);
        chk({nm, ".out_valid"}, v, e_valid[d]);
        chk({nm, ".done"}, dn, e_done[d]);
        if (e_valid[d]) chk({nm, ".out_bits"}, b, e_bits[d]);
    endtask

    // Reference model advances on the same edges as the DUTs.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, ifa.in_valid, ifa.in_data, ifa.stop);
            model_step(1, ifb.in_valid, ifb.in_data, ifb.stop);
        end
    end

    // Compare and capture on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            compare(0, ifa.in_ready, ifa.out_valid, ifa.out_bits, ifa.done);
            if (ifa.out_valid) cap_a.push_back(ifa.out_bits);
            if (ifa.done) done_cnt_a++;
            compare(1, ifb.in_ready, ifb.out_valid, ifb.out_bits, ifb.done);
            if (ifb.out_valid) cap_b.push_back(ifb.out_bits);
            vb.push_back(ifb.out_valid);
        end
    end

    function automatic int ones_a(input int ch);
        int c;
        c = 0;
        foreach (cap_a[i]) c += int'(cap_a[i][ch]);
        return c;
    endfunction

    task automatic load_a(input bit [15:0] data, input bit st);
        @(negedge clk); #1;
        cap_a.delete();
        done_cnt_a   = 0;
        ifa.in_valid = 1'b1;
        ifa.in_data  = data;
        ifa.stop     = st;
        @(negedge clk); #1;
        ifa.in_valid = 1'b0;
        ifa.stop     = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk); #1;
            if (ifa.done) break;
            n++;
        end
        chk("A.done_seen", ifa.done, 1);
        chk("A.ready_with_done", ifa.in_ready, 1);
    endtask

    initial begin
        bit [15:0] d;
        bit        ok;
        int        f, rises;

        rst = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.stop = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.stop = 1'b0;
        repeat (2) @(negedge clk);
        chk("A.reset_in_ready", ifa.in_ready, 1);
        chk("A.reset_out_valid", ifa.out_valid, 0);
        chk("A.reset_out_bits", ifa.out_bits, 0);
        chk("A.reset_done", ifa.done, 0);
        chk("B.reset_in_ready", ifb.in_ready, 1);
        #1 rst = 1'b1;

        // Full-period exactness on hand-known values.
        load_a(16'hFF40, 1'b0);
        wait_done_a(400);
        chk("A.t1_len", cap_a.size(), 255);
        chk("A.t1_ch0_ones", ones_a(0), 64);
        chk("A.t1_ch1_ones", ones_a(1), 255);
        chk("A.t1_done_pulses", done_cnt_a, 1);
        first_stream = cap_a;

        load_a(16'h0100, 1'b0);
        wait_done_a(400);
        chk("A.t2_ch0_ones", ones_a(0), 0);
        chk("A.t2_ch1_ones", ones_a(1), 1);

        // Random values; the last load also raises stop in IDLE, which must lose.
        for (int it = 0; it < 4; it++) begin
            d = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            load_a(d, (it == 3));
            wait_done_a(400);
            chk("A.rand_ch0_ones", ones_a(0), int'(d[7:0]));
            chk("A.rand_ch1_ones", ones_a(1), int'(d[15:8]));
        end

        // Abort after bit 100, then reload the same value.
        d = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        load_a(d, 1'b0);
        repeat (100) @(negedge clk);
        #1 ifa.stop = 1'b1;
        @(negedge clk); #1;
        ifa.stop = 1'b0;
        chk("A.stop_out_valid", ifa.out_valid, 0);
        chk("A.stop_in_ready", ifa.in_ready, 1);
        chk("A.stop_bits_before", cap_a.size(), 100);
        repeat (3) @(negedge clk);
        #1 chk("A.stop_no_done", done_cnt_a, 0);
        first_stream = cap_a;
        load_a(d, 1'b0);
        wait_done_a(400);
        chk("A.restart_len", cap_a.size(), 255);
        ok = 1'b1;
        for (int i = 0; i < 100; i++) if (cap_a[i] != first_stream[i]) ok = 1'b0;
        chk("A.restart_prefix_match", ok, 1);

        // Asynchronous reset in the middle of a stream.
        load_a(16'hFF40, 1'b0);
        repeat (50) @(negedge clk);
        @(posedge clk); #2;
        chk("A.pre_reset_valid", ifa.out_valid, 1);
        rst = 1'b0;
        #1;
        chk("A.async_out_valid", ifa.out_valid, 0);
        chk("A.async_out_bits", ifa.out_bits, 0);
        chk("A.async_done", ifa.done, 0);
        chk("A.async_in_ready", ifa.in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        load_a(16'hFF40, 1'b0);
        first_stream.delete();
        wait_done_a(400);
        chk("A.post_reset_ch0_ones", ones_a(0), 64);
        chk("A.post_reset_ch1_ones", ones_a(1), 255);

        // Shared RNG: ch1 value below ch0 value means ch1 ones imply ch0 ones.
        @(negedge clk); #1;
        cap_b.delete();
        ifb.in_valid = 1'b1;
        ifb.in_data  = 16'h3080;
        @(negedge clk); #1;
        ifb.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("B.shared_len", cap_b.size(), 16);
        ok = 1'b1;
        foreach (cap_b[i]) if (cap_b[i][1] && !cap_b[i][0]) ok = 1'b0;
        chk("B.shared_subset", ok, 1);

        // in_valid held high with changing data: 16-bit streams, one idle cycle apart.
        @(negedge clk); #1;
        vb.delete();
        ifb.in_valid = 1'b1;
        for (int i = 0; i < 120; i++) begin
            ifb.in_data = 16'($urandom);
            @(negedge clk); #1;
        end
        ifb.in_valid = 1'b0;
        f = -1;
        ok = 1'b1;
        rises = 0;
        for (int i = 0; i < 120; i++) begin
            if (f < 0 && vb[i]) f = i;
            if (f >= 0 && vb[i] != (((i - f) % 17) < 16)) ok = 1'b0;
            if (vb[i] && (i == 0 || !vb[i-1])) rises++;
        end
        chk("B.first_valid_idx", f, 1);
        chk("B.cadence", ok, 1);
        chk("B.stream_count", rises, 7);
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
